// File: rtl/round_robin_shared_adder_pkg.sv
// Shared types and the round-robin grant search for the shared adder.
// rr_pick works on a fixed 16-bit request vector so one function serves every n_req.
package round_robin_shared_adder_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_t;

  localparam int MAX_REQ = 16;
  localparam int PTR_W   = 4;
  localparam int IDX_W   = PTR_W + 1;

  // First set bit of req at or after last+1, wrapping modulo n; returns last if none.
  function automatic logic [PTR_W-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                               input logic [PTR_W-1:0]   last,
                                               input logic [IDX_W-1:0]   n);
    logic [PTR_W-1:0] g;
    logic             found;
    logic [IDX_W-1:0] idx;
    g     = last;
    found = 1'b0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      idx = {1'b0, last} + IDX_W'(k);
      if (idx >= n) idx = idx - n;
      if (!found && (IDX_W'(k) <= n) && req[idx[PTR_W-1:0]]) begin
        g     = idx[PTR_W-1:0];
        found = 1'b1;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/round_robin_shared_adder_buffer.sv
// Two-entry FIFO between the shared adder and the downstream consumer.
// up_ready is decoded from the registered state only, so out_ready never reaches the upstream side.
module tagged_double_buffer
  import round_robin_shared_adder_pkg::*;
#(
  parameter int data_w = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [data_w-1:0] in_data,
  output logic              up_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [data_w-1:0] out_data
);

  buf_state_t        state;
  logic [data_w-1:0] head_p1;
  logic [data_w-1:0] tail_p1;
  logic              push;
  logic              pop;

  assign up_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign out_data  = head_p1;
  assign push      = in_valid & up_ready;
  assign pop       = out_valid & out_ready;

  // Stage p1: head is always the oldest entry, tail only used while FULL.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= EMPTY;
      head_p1 <= '0;
      tail_p1 <= '0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (push) begin
            head_p1 <= in_data;
            state   <= ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            head_p1 <= in_data;
          end else if (push) begin
            tail_p1 <= in_data;
            state   <= FULL;
          end else if (pop) begin
            state   <= EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            head_p1 <= tail_p1;
            state   <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/round_robin_shared_adder.sv
// One width-bit adder shared by n_req requesters through a round-robin arbiter.
// Results are tagged with the requester id and queued in a two-entry output buffer.
module round_robin_shared_adder
  import round_robin_shared_adder_pkg::*;
#(
  parameter  int width = 8,
  parameter  int n_req = 4,
  localparam int id_w  = $clog2(n_req)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [n_req-1:0]       req_valid,
  output logic [n_req-1:0]       req_ready,
  input  logic [n_req*width-1:0] req_a,
  input  logic [n_req*width-1:0] req_b,
  output logic                   sum_valid,
  input  logic                   sum_ready,
  output logic [width-1:0]       sum_data,
  output logic                   sum_carry,
  output logic [id_w-1:0]        sum_id
);

  localparam int data_w = id_w + 1 + width;

  logic [id_w-1:0]   last;
  logic [id_w-1:0]   grant;
  logic [width-1:0]  op_a_p0;
  logic [width-1:0]  op_b_p0;
  logic [width:0]    sum_p0;
  logic              vld_p0;
  logic              up_ready;
  logic [data_w-1:0] out_data;

  function automatic logic [width:0] add_carry(input logic [width-1:0] a,
                                               input logic [width-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  // Stage p0: arbitration, operand select and the shared add, all combinational.
  assign grant   = id_w'(rr_pick(MAX_REQ'(req_valid), PTR_W'(last), IDX_W'(n_req)));
  assign op_a_p0 = req_a[grant*width +: width];
  assign op_b_p0 = req_b[grant*width +: width];
  assign sum_p0  = add_carry(op_a_p0, op_b_p0);
  assign vld_p0  = req_valid[grant];

  // Gating with rst keeps every requester stalled while reset is held.
  always_comb begin
    req_ready = '0;
    if (rst && (|req_valid)) req_ready[grant] = up_ready;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last <= id_w'(n_req - 1);
    end else if (vld_p0 && up_ready) begin
      last <= grant;
    end
  end

  // Stage p1: tagged results wait in the output buffer.
  tagged_double_buffer #(
    .data_w (data_w)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (vld_p0),
    .in_data   ({grant, sum_p0}),
    .up_ready  (up_ready),
    .out_valid (sum_valid),
    .out_ready (sum_ready),
    .out_data  (out_data)
  );

  assign {sum_id, sum_carry, sum_data} = out_data;

endmodule
